// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS control sequencer: opcodes, FSM states,
// phase encodings and instruction field positions.
package mips_pkg;

    localparam int WORD_W = 16;
    localparam int OP_W   = 4;
    localparam int REG_W  = 4;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_BEQ  = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RS_MSB = 11;
    localparam int RS_LSB = 8;
    localparam int RT_MSB = 7;
    localparam int RT_LSB = 4;
    localparam int RD_MSB = 3;
    localparam int RD_LSB = 0;
    localparam int TGT_MSB = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [3:0] TMR_IDLE   = 4'b0000;
    localparam logic [3:0] TMR_FETCH  = 4'b0001;
    localparam logic [3:0] TMR_DECODE = 4'b0010;
    localparam logic [3:0] TMR_EXEC   = 4'b0100;
    localparam logic [3:0] TMR_WB     = 4'b1000;
    localparam logic [3:0] TMR_HALT   = 4'b0000;

    function automatic logic [3:0] timer_of(input state_t s);
        case (s)
            ST_FETCH:  return TMR_FETCH;
            ST_DECODE: return TMR_DECODE;
            ST_EXEC:   return TMR_EXEC;
            ST_WB:     return TMR_WB;
            ST_HALT:   return TMR_HALT;
            default:   return TMR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction decoder: op class, ALU select, sign-extended branch
// offset and zero-extended jump target.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] i_ir,
    output op_class_t         o_class,
    output logic [OP_W-1:0]   o_sel,
    output logic [WORD_W-1:0] o_offset,
    output logic [WORD_W-1:0] o_target
);

    logic [OP_W-1:0] w_op;

    assign w_op = i_ir[OP_MSB:OP_LSB];

    always_comb begin
        o_class = CLS_ILLEGAL;
        o_sel   = '0;
        case (w_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
                o_class = CLS_ALU;
                o_sel   = w_op;
            end
            OP_BEQ: begin
                // equality is tested as a subtract that yields zero
                o_class = CLS_BRANCH;
                o_sel   = OP_SUB;
            end
            OP_JMP:  o_class = CLS_JUMP;
            OP_NOP:  o_class = CLS_NOP;
            OP_HALT: o_class = CLS_HALT;
            default: o_class = CLS_ILLEGAL;
        endcase
    end

    assign o_offset = {{(WORD_W-4){i_ir[RD_MSB]}}, i_ir[RD_MSB:RD_LSB]};
    assign o_target = {{(WORD_W-12){1'b0}}, i_ir[TGT_MSB:0]};

endmodule

// File: rtl/mips_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the 16-bit MIPS datapath.
// Strobes are registered on the edge entering the phase in which they are seen.
module mips_ctrl_seq
    import mips_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int OP_SIZE   = 4,
    parameter int REG_ADDR  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 key_ok,
    output logic                 instr_req,
    input  logic                 instr_valid,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 alu_zero_flag,
    output logic [OP_SIZE-1:0]   sel,
    output logic [REG_ADDR-1:0]  rf_ra,
    output logic [REG_ADDR-1:0]  rf_rb,
    output logic [REG_ADDR-1:0]  rf_wa,
    output logic                 rf_we,
    output logic                 pc_inc,
    output logic                 load_pc,
    output logic [WORD_SIZE-1:0] data_in,
    output logic                 offset,
    output logic [WORD_SIZE-1:0] offset_val,
    output logic [3:0]           timer,
    output logic                 halted,
    output logic                 illegal
);

    state_t              r_state;
    state_t              w_state_next;
    state_t              w_eoi_state;
    logic [WORD_SIZE-1:0] r_ir;
    logic [WORD_SIZE-1:0] w_ir_next;
    logic                w_accept;

    op_class_t           w_class;
    logic [OP_SIZE-1:0]  w_sel;
    logic [WORD_SIZE-1:0] w_offset;
    logic [WORD_SIZE-1:0] w_target;

    logic [OP_SIZE-1:0]  r_sel;
    logic [REG_ADDR-1:0] r_rf_wa;
    logic                r_rf_we;
    logic                r_pc_inc;
    logic                r_load_pc;
    logic [WORD_SIZE-1:0] r_data_in;
    logic                r_offset;
    logic [WORD_SIZE-1:0] r_offset_val;
    logic [3:0]          r_timer;
    logic                r_halted;
    logic                r_illegal;

    assign w_accept  = (r_state == ST_FETCH) && instr_valid;
    // Decoding the incoming word on the accept cycle lets DECODE-phase strobes be registered.
    assign w_ir_next = w_accept ? instr : r_ir;

    mips_ctrl_decode u_decode (
        .i_ir     (w_ir_next),
        .o_class  (w_class),
        .o_sel    (w_sel),
        .o_offset (w_offset),
        .o_target (w_target)
    );

    assign w_eoi_state = key_ok ? ST_FETCH : ST_IDLE;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (key_ok) w_state_next = ST_FETCH;
            ST_FETCH:  if (instr_valid) w_state_next = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CLS_JUMP, CLS_NOP, CLS_ILLEGAL: w_state_next = w_eoi_state;
                    CLS_HALT:                       w_state_next = ST_HALT;
                    default:                        w_state_next = ST_EXEC;
                endcase
            end
            ST_EXEC:   w_state_next = (w_class == CLS_ALU) ? ST_WB : w_eoi_state;
            ST_WB:     w_state_next = w_eoi_state;
            ST_HALT:   w_state_next = ST_HALT;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_ir         <= '0;
            r_sel        <= '0;
            r_rf_wa      <= '0;
            r_rf_we      <= 1'b0;
            r_pc_inc     <= 1'b0;
            r_load_pc    <= 1'b0;
            r_data_in    <= '0;
            r_offset     <= 1'b0;
            r_offset_val <= '0;
            r_timer      <= TMR_IDLE;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= timer_of(w_state_next);
            // A jump replaces the PC outright, so it takes the load slot instead of the increment.
            r_pc_inc  <= w_accept && (w_class != CLS_JUMP);
            r_load_pc <= w_accept && (w_class == CLS_JUMP);
            r_illegal <= w_accept && (w_class == CLS_ILLEGAL);
            r_offset  <= (r_state == ST_EXEC) && (w_class == CLS_BRANCH) && alu_zero_flag;
            r_rf_we   <= (r_state == ST_EXEC) && (w_class == CLS_ALU);
            r_sel     <= (w_state_next == ST_EXEC || w_state_next == ST_WB) ? w_sel : '0;
            if (w_accept) begin
                r_ir <= instr;
                if (w_class == CLS_JUMP)   r_data_in    <= w_target;
                if (w_class == CLS_BRANCH) r_offset_val <= w_offset;
            end
            if ((r_state == ST_EXEC) && (w_class == CLS_ALU))
                r_rf_wa <= r_ir[RD_MSB:RD_LSB];
            if (w_state_next == ST_HALT)
                r_halted <= 1'b1;
        end
    end

    assign instr_req  = (r_state == ST_FETCH);
    assign rf_ra      = r_ir[RS_MSB:RS_LSB];
    assign rf_rb      = r_ir[RT_MSB:RT_LSB];
    assign sel        = r_sel;
    assign rf_wa      = r_rf_wa;
    assign rf_we      = r_rf_we;
    assign pc_inc     = r_pc_inc;
    assign load_pc    = r_load_pc;
    assign data_in    = r_data_in;
    assign offset     = r_offset;
    assign offset_val = r_offset_val;
    assign timer      = r_timer;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_mips_ctrl_seq.sv
// Directed self-checking bench for mips_ctrl_seq; outputs are observed 1ns after each rising edge.
`timescale 1ns/1ps
module tb_mips_ctrl_seq;

    logic        clk;
    logic        rstn;
    logic        key_ok;
    logic        instr_req;
    logic        instr_valid;
    logic [15:0] instr;
    logic        alu_zero_flag;
    logic [3:0]  sel;
    logic [3:0]  rf_ra;
    logic [3:0]  rf_rb;
    logic [3:0]  rf_wa;
    logic        rf_we;
    logic        pc_inc;
    logic        load_pc;
    logic [15:0] data_in;
    logic        offset;
    logic [15:0] offset_val;
    logic [3:0]  timer;
    logic        halted;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    mips_ctrl_seq dut (
        .clk           (clk),
        .rstn          (rstn),
        .key_ok        (key_ok),
        .instr_req     (instr_req),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .alu_zero_flag (alu_zero_flag),
        .sel           (sel),
        .rf_ra         (rf_ra),
        .rf_rb         (rf_rb),
        .rf_wa         (rf_wa),
        .rf_we         (rf_we),
        .pc_inc        (pc_inc),
        .load_pc       (load_pc),
        .data_in       (data_in),
        .offset        (offset),
        .offset_val    (offset_val),
        .timer         (timer),
        .halted        (halted),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        key_ok = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0000;
        alu_zero_flag = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (timer !== 4'b0000) begin n_errors++; $display("FAIL reset_timer: got %b expected 0000", timer); end
        n_checks++; if (instr_req !== 1'b0) begin n_errors++; $display("FAIL reset_instr_req: got %b expected 0", instr_req); end
        n_checks++; if ({sel, rf_ra, rf_rb, rf_wa} !== 16'h0000) begin n_errors++; $display("FAIL reset_addr_sel: got %h expected 0000", {sel, rf_ra, rf_rb, rf_wa}); end
        n_checks++; if ({rf_we, pc_inc, load_pc, offset, halted, illegal} !== 6'b0) begin n_errors++; $display("FAIL reset_strobes: got %b expected 000000", {rf_we, pc_inc, load_pc, offset, halted, illegal}); end
        n_checks++; if ({data_in, offset_val} !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 00000000", {data_in, offset_val}); end
        step();
        n_checks++; if (timer !== 4'b0000) begin n_errors++; $display("FAIL idle_hold_timer: got %b expected 0000", timer); end
        $display("test_reset done");
    endtask

    task automatic test_alu_add();
        apply_reset();
        key_ok = 1'b1; instr = 16'h7123; instr_valid = 1'b1;
        step();
        n_checks++; if (timer !== 4'b0001 || instr_req !== 1'b1 || pc_inc !== 1'b0) begin n_errors++; $display("FAIL add_fetch: got timer=%b req=%b pc_inc=%b expected 0001/1/0", timer, instr_req, pc_inc); end
        step();
        n_checks++; if (timer !== 4'b0010 || pc_inc !== 1'b1 || instr_req !== 1'b0) begin n_errors++; $display("FAIL add_decode: got timer=%b pc_inc=%b req=%b expected 0010/1/0", timer, pc_inc, instr_req); end
        n_checks++; if (rf_ra !== 4'h1 || rf_rb !== 4'h2 || sel !== 4'h0 || rf_we !== 1'b0) begin n_errors++; $display("FAIL add_decode_regs: got ra=%h rb=%h sel=%b we=%b expected 1/2/0000/0", rf_ra, rf_rb, sel, rf_we); end
        step();
        n_checks++; if (timer !== 4'b0100 || sel !== 4'b0111 || rf_we !== 1'b0 || pc_inc !== 1'b0) begin n_errors++; $display("FAIL add_exec: got timer=%b sel=%b we=%b pc_inc=%b expected 0100/0111/0/0", timer, sel, rf_we, pc_inc); end
        step();
        n_checks++; if (timer !== 4'b1000 || sel !== 4'b0111 || rf_we !== 1'b1 || rf_wa !== 4'h3) begin n_errors++; $display("FAIL add_wb: got timer=%b sel=%b we=%b wa=%h expected 1000/0111/1/3", timer, sel, rf_we, rf_wa); end
        n_checks++; if (rf_ra !== 4'h1 || rf_rb !== 4'h2) begin n_errors++; $display("FAIL add_wb_regs_stable: got ra=%h rb=%h expected 1/2", rf_ra, rf_rb); end
        instr_valid = 1'b0;
        step();
        n_checks++; if (timer !== 4'b0001 || rf_we !== 1'b0 || sel !== 4'h0 || instr_req !== 1'b1) begin n_errors++; $display("FAIL add_next_fetch: got timer=%b we=%b sel=%b req=%b expected 0001/0/0000/1", timer, rf_we, sel, instr_req); end
        $display("test_alu_add done");
    endtask

    task automatic test_beq(input logic zero);
        apply_reset();
        key_ok = 1'b1; instr = 16'h311E; instr_valid = 1'b1;
        step();
        step();
        instr_valid = 1'b0; alu_zero_flag = zero;
        n_checks++; if (timer !== 4'b0010 || pc_inc !== 1'b1 || load_pc !== 1'b0) begin n_errors++; $display("FAIL beq_decode: got timer=%b pc_inc=%b load_pc=%b expected 0010/1/0", timer, pc_inc, load_pc); end
        step();
        n_checks++; if (timer !== 4'b0100 || sel !== 4'b1000 || offset !== 1'b0 || rf_we !== 1'b0) begin n_errors++; $display("FAIL beq_exec: got timer=%b sel=%b offset=%b we=%b expected 0100/1000/0/0", timer, sel, offset, rf_we); end
        step();
        n_checks++; if (timer !== 4'b0001 || rf_we !== 1'b0 || sel !== 4'h0 || pc_inc !== 1'b0) begin n_errors++; $display("FAIL beq_end: got timer=%b we=%b sel=%b pc_inc=%b expected 0001/0/0000/0", timer, rf_we, sel, pc_inc); end
        n_checks++; if (offset !== zero) begin n_errors++; $display("FAIL beq_offset_z%0d: got %b expected %b", zero, offset, zero); end
        n_checks++; if (offset_val !== 16'hFFFE) begin n_errors++; $display("FAIL beq_offset_val: got %h expected fffe", offset_val); end
        step();
        n_checks++; if (offset !== 1'b0) begin n_errors++; $display("FAIL beq_offset_single: got %b expected 0", offset); end
        alu_zero_flag = 1'b0;
        $display("test_beq zero=%0d done", zero);
    endtask

    task automatic test_jmp();
        apply_reset();
        key_ok = 1'b1; instr = 16'h4ABC; instr_valid = 1'b1;
        step();
        step();
        instr_valid = 1'b0;
        n_checks++; if (timer !== 4'b0010 || load_pc !== 1'b1 || data_in !== 16'h0ABC) begin n_errors++; $display("FAIL jmp_decode: got timer=%b load_pc=%b data_in=%h expected 0010/1/0abc", timer, load_pc, data_in); end
        n_checks++; if (pc_inc !== 1'b0 || offset !== 1'b0) begin n_errors++; $display("FAIL jmp_exclusive: got pc_inc=%b offset=%b expected 0/0", pc_inc, offset); end
        step();
        n_checks++; if (timer !== 4'b0001 || load_pc !== 1'b0) begin n_errors++; $display("FAIL jmp_next: got timer=%b load_pc=%b expected 0001/0", timer, load_pc); end
        $display("test_jmp done");
    endtask

    task automatic test_fetch_stall();
        apply_reset();
        key_ok = 1'b1; instr = 16'h7123; instr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if (timer !== 4'b0001 || instr_req !== 1'b1 || pc_inc !== 1'b0) begin n_errors++; $display("FAIL stall_cycle%0d: got timer=%b req=%b pc_inc=%b expected 0001/1/0", i, timer, instr_req, pc_inc); end
        end
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        n_checks++; if (timer !== 4'b0010 || pc_inc !== 1'b1) begin n_errors++; $display("FAIL stall_accept: got timer=%b pc_inc=%b expected 0010/1", timer, pc_inc); end
        $display("test_fetch_stall done");
    endtask

    task automatic test_key_drop();
        apply_reset();
        key_ok = 1'b1; instr = 16'h8456; instr_valid = 1'b1;
        step();
        step();
        instr_valid = 1'b0;
        step();
        n_checks++; if (timer !== 4'b0100 || sel !== 4'b1000) begin n_errors++; $display("FAIL sub_exec: got timer=%b sel=%b expected 0100/1000", timer, sel); end
        key_ok = 1'b0;
        step();
        n_checks++; if (timer !== 4'b1000 || rf_we !== 1'b1 || rf_wa !== 4'h6) begin n_errors++; $display("FAIL keydrop_wb: got timer=%b we=%b wa=%h expected 1000/1/6", timer, rf_we, rf_wa); end
        step();
        n_checks++; if (timer !== 4'b0000 || instr_req !== 1'b0 || rf_we !== 1'b0) begin n_errors++; $display("FAIL keydrop_idle: got timer=%b req=%b we=%b expected 0000/0/0", timer, instr_req, rf_we); end
        step();
        n_checks++; if (timer !== 4'b0000 || instr_req !== 1'b0) begin n_errors++; $display("FAIL keydrop_idle_hold: got timer=%b req=%b expected 0000/0", timer, instr_req); end
        $display("test_key_drop done");
    endtask

    task automatic test_halt();
        apply_reset();
        key_ok = 1'b1; instr = 16'hF000; instr_valid = 1'b1;
        step();
        step();
        n_checks++; if (timer !== 4'b0010 || halted !== 1'b0) begin n_errors++; $display("FAIL halt_decode: got timer=%b halted=%b expected 0010/0", timer, halted); end
        step();
        n_checks++; if (halted !== 1'b1 || timer !== 4'b0000 || instr_req !== 1'b0) begin n_errors++; $display("FAIL halt_enter: got halted=%b timer=%b req=%b expected 1/0000/0", halted, timer, instr_req); end
        for (int i = 0; i < 4; i++) begin
            key_ok = i[0];
            step();
            n_checks++; if (halted !== 1'b1 || timer !== 4'b0000 || instr_req !== 1'b0 || {pc_inc, load_pc, offset, rf_we} !== 4'b0) begin n_errors++; $display("FAIL halt_sticky%0d: got halted=%b timer=%b req=%b strobes=%b expected 1/0000/0/0000", i, halted, timer, instr_req, {pc_inc, load_pc, offset, rf_we}); end
        end
        instr_valid = 1'b0;
        $display("test_halt done");
    endtask

    task automatic test_illegal();
        apply_reset();
        key_ok = 1'b1; instr = 16'hA000; instr_valid = 1'b1;
        step();
        n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL illegal_fetch: got %b expected 0", illegal); end
        step();
        instr_valid = 1'b0;
        n_checks++; if (illegal !== 1'b1 || timer !== 4'b0010) begin n_errors++; $display("FAIL illegal_decode: got illegal=%b timer=%b expected 1/0010", illegal, timer); end
        step();
        n_checks++; if (illegal !== 1'b0 || timer !== 4'b0001 || sel !== 4'h0) begin n_errors++; $display("FAIL illegal_end: got illegal=%b timer=%b sel=%b expected 0/0001/0000", illegal, timer, sel); end
        $display("test_illegal done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        key_ok = 1'b1; instr = 16'h7123; instr_valid = 1'b1;
        step();
        step();
        instr_valid = 1'b0;
        step();
        n_checks++; if (sel !== 4'b0111 || timer !== 4'b0100) begin n_errors++; $display("FAIL rmid_exec: got sel=%b timer=%b expected 0111/0100", sel, timer); end
        rstn = 1'b0;
        #1;
        n_checks++; if ({timer, sel, rf_ra, rf_rb} !== 16'h0000 || instr_req !== 1'b0) begin n_errors++; $display("FAIL rmid_async: got timer=%b sel=%b ra=%h rb=%h req=%b expected all zero", timer, sel, rf_ra, rf_rb, instr_req); end
        step();
        n_checks++; if (rf_we !== 1'b0 || rf_wa !== 4'h0 || timer !== 4'b0000) begin n_errors++; $display("FAIL rmid_no_wb: got we=%b wa=%h timer=%b expected 0/0/0000", rf_we, rf_wa, timer); end
        rstn = 1'b1;
        step();
        n_checks++; if (timer !== 4'b0001) begin n_errors++; $display("FAIL rmid_restart: got timer=%b expected 0001", timer); end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        key_ok = 1'b1; instr = 16'h6789; instr_valid = 1'b1;
        step();
        step();
        instr = 16'h4ABC;
        step();
        n_checks++; if (sel !== 4'b0110) begin n_errors++; $display("FAIL b2b_or_sel: got %b expected 0110", sel); end
        step();
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 4'h9) begin n_errors++; $display("FAIL b2b_or_wb: got we=%b wa=%h expected 1/9", rf_we, rf_wa); end
        step();
        step();
        instr_valid = 1'b0;
        n_checks++; if (load_pc !== 1'b1 || data_in !== 16'h0ABC || rf_ra !== 4'hA || rf_rb !== 4'hB) begin n_errors++; $display("FAIL b2b_jmp: got load_pc=%b data_in=%h ra=%h rb=%h expected 1/0abc/a/b", load_pc, data_in, rf_ra, rf_rb); end
        $display("test_back_to_back done");
    endtask

    initial begin
        rstn = 1'b0;
        key_ok = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0000;
        alu_zero_flag = 1'b0;
        test_reset();
        test_alu_add();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jmp();
        test_fetch_stall();
        test_key_drop();
        test_halt();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
